display_feeder: RTL and testbench

DISPLAY_FEEDER -- requirements
Module: display_feeder

---
 rtl/display_feeder.sv | 126 ++++++++++++
 tb/tb_display_feeder.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/display_feeder.sv
// Averages windows of signed samples and, on each display tick, publishes the
// latest completed average as a clamped magnitude, sign character and label.
module display_feeder #(
  parameter int CLK_DIV  = 5000000,
  parameter int AVG_LOG2 = 3
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic [15:0] IN_DATA,
  input  logic        IN_VALID,
  output logic        IN_READY,
  input  logic [6:0]  LABEL,
  output logic [15:0] NUM_OUT,
  output logic [13:0] CHAR_OUT,
  output logic        UPDATE,
  output logic        OVF
);
  localparam int AW = 16 + AVG_LOG2;
  localparam int CW = AVG_LOG2 + 1;
  localparam int TW = $clog2(CLK_DIV);
  localparam logic [CW-1:0] WIN_LAST  = CW'((1 << AVG_LOG2) - 1);
  localparam logic [TW-1:0] TICK_LAST = TW'(CLK_DIV - 1);
  localparam logic [6:0]    CH_SPACE  = 7'h20;
  localparam logic [6:0]    CH_MINUS  = 7'h2D;

  typedef enum logic {ACCUM = 1'b0, PUBLISH = 1'b1} state_t;

  state_t               state_q, state_d;
  logic [TW-1:0]        tick_q;
  logic [CW-1:0]        cnt_q;
  logic signed [AW-1:0] acc_q;
  logic signed [AW-1:0] sum_d;
  logic [15:0]          pend_q;
  logic [15:0]          pub_q;
  logic                 pend_valid_q;
  logic                 ready_q;
  logic                 update_q;
  logic                 ovf_q;
  logic [15:0]          num_q;
  logic [13:0]          char_q;

  logic        tick, accept, win_done, pub_start;
  logic [16:0] mag_d;
  logic [15:0] num_d;
  logic        ovf_d;
  logic [6:0]  sign_d;

  assign tick     = (tick_q == TICK_LAST);
  assign accept   = IN_VALID && ready_q;
  assign win_done = accept && (cnt_q == WIN_LAST);
  // Window sum always fits: 2^AVG_LOG2 samples of 16 bits need 16+AVG_LOG2 bits.
  assign sum_d    = acc_q + AW'($signed(IN_DATA));

  always_comb begin
    state_d   = state_q;
    pub_start = 1'b0;
    case (state_q)
      ACCUM: begin
        if (tick && pend_valid_q) begin
          state_d   = PUBLISH;
          pub_start = 1'b1;
        end
      end
      PUBLISH: state_d = ACCUM;
      default: state_d = ACCUM;
    endcase
  end

  // Magnitude needs 17 bits so that -32768 maps to 32768 before clamping.
  always_comb begin
    mag_d  = pub_q[15] ? (17'd0 - {pub_q[15], pub_q}) : {1'b0, pub_q};
    ovf_d  = (mag_d > 17'd9999);
    num_d  = ovf_d ? 16'd9999 : mag_d[15:0];
    sign_d = pub_q[15] ? CH_MINUS : CH_SPACE;
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q      <= ACCUM;
      tick_q       <= '0;
      cnt_q        <= '0;
      acc_q        <= '0;
      pend_q       <= '0;
      pub_q        <= '0;
      pend_valid_q <= 1'b0;
      ready_q      <= 1'b0;
      update_q     <= 1'b0;
      ovf_q        <= 1'b0;
      num_q        <= '0;
      char_q       <= {CH_SPACE, CH_SPACE};
    end else begin
      state_q  <= state_d;
      ready_q  <= (state_d == ACCUM);
      tick_q   <= tick ? '0 : tick_q + TW'(1);
      update_q <= (state_q == PUBLISH);

      if (accept) begin
        if (win_done) begin
          acc_q  <= '0;
          cnt_q  <= '0;
          pend_q <= sum_d[AW-1:AVG_LOG2];
        end else begin
          acc_q <= sum_d;
          cnt_q <= cnt_q + CW'(1);
        end
      end

      // Snapshot at publish start so a window finishing on the tick stays pending.
      if (pub_start) pub_q <= pend_q;
      if (win_done) pend_valid_q <= 1'b1;
      else if (pub_start) pend_valid_q <= 1'b0;

      if (state_q == PUBLISH) begin
        num_q  <= num_d;
        ovf_q  <= ovf_d;
        char_q <= {LABEL, sign_d};
      end
    end
  end

  assign IN_READY = ready_q;
  assign NUM_OUT  = num_q;
  assign CHAR_OUT = char_q;
  assign UPDATE   = update_q;
  assign OVF      = ovf_q;
endmodule

// File: tb/tb_display_feeder.sv
// Randomized and directed bench for display_feeder with a window/tick reference
// model; a monitor compares every UPDATE and checks that outputs hold otherwise.
module tb_display_feeder;
  localparam int CLK_DIV  = 16;
  localparam int AVG_LOG2 = 2;
  localparam int WIN      = 1 << AVG_LOG2;

  logic        clk;
  logic        rst;
  logic [15:0] in_data;
  logic        in_valid;
  logic        in_ready;
  logic [6:0]  label;
  logic [15:0] num_out;
  logic [13:0] char_out;
  logic        update;
  logic        ovf;

  display_feeder #(.CLK_DIV(CLK_DIV), .AVG_LOG2(AVG_LOG2)) dut (
    .CLK(clk), .RST(rst), .IN_DATA(in_data), .IN_VALID(in_valid),
    .IN_READY(in_ready), .LABEL(label), .NUM_OUT(num_out),
    .CHAR_OUT(char_out), .UPDATE(update), .OVF(ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] num;
    logic [13:0] ch;
    logic        ovf;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  function automatic void check(string name, longint act, longint req);
    n_cmp++;
    if (act != req) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
    end
  endfunction

  // Reference model: cycle index since reset release, sample window, pending value.
  int         cyc;
  int         win[$];
  int         m_pend;
  bit         m_pend_v;
  bit         m_pub;
  int         m_pubval;
  logic [6:0] lab_cur;

  function automatic int floor_avg(int s);
    return (s >= 0) ? s / WIN : -((-s + WIN - 1) / WIN);
  endfunction

  function automatic exp_t mk_exp(int avg, logic [6:0] lab);
    exp_t e;
    int   mag;
    mag   = (avg < 0) ? -avg : avg;
    e.ovf = (mag > 9999);
    e.num = 16'((mag > 9999) ? 9999 : mag);
    e.ch  = {lab, (avg < 0) ? 7'h2D : 7'h20};
    return e;
  endfunction

  task automatic cycle(input logic v, input logic [15:0] d, output bit acc);
    bit   rdy;
    int   s;
    exp_t e;
    @(negedge clk);
    rdy = (cyc >= 1) && !m_pub;
    check("in_ready", in_ready, rdy);
    in_valid = v;
    in_data  = d;
    label    = lab_cur;
    acc      = v && rdy;
    if (m_pub) begin
      e = mk_exp(m_pubval, lab_cur);
      exp_q.push_back(e);
      $display("publish expected: num=%0d char=%h ovf=%0b", e.num, e.ch, e.ovf);
      m_pub = 1'b0;
    end else if ((cyc % CLK_DIV) == CLK_DIV - 1 && m_pend_v) begin
      m_pubval = m_pend;
      m_pend_v = 1'b0;
      m_pub    = 1'b1;
    end
    if (acc) begin
      win.push_back(int'($signed(d)));
      if (win.size() == WIN) begin
        s = 0;
        foreach (win[i]) s += win[i];
        m_pend   = floor_avg(s);
        m_pend_v = 1'b1;
        win.delete();
      end
    end
    cyc++;
  endtask

  task automatic idle(input int n);
    bit a;
    for (int i = 0; i < n; i++) cycle(1'b0, 16'($urandom), a);
  endtask

  task automatic send(input logic [15:0] d);
    bit a;
    a = 1'b0;
    for (int i = 0; i < 40 && !a; i++) cycle(1'b1, d, a);
    check("send accepted", a, 1);
  endtask

  task automatic reset_dut();
    @(negedge clk);
    rst      = 1'b1;
    in_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst      = 1'b0;
    win.delete();
    m_pend   = 0;
    m_pend_v = 1'b0;
    m_pub    = 1'b0;
    cyc      = 1;  // cycle 0 is this deassert cycle: no tick, not ready
  endtask

  // Monitor: samples just after each rising edge.
  exp_t last;
  always @(posedge clk) begin
    exp_t e;
    #2;
    if (rst) begin
      exp_q.delete();
      last.num = 16'd0;
      last.ch  = 14'h1020;
      last.ovf = 1'b0;
      check("reset num_out", num_out, 0);
      check("reset char_out", char_out, 14'h1020);
      check("reset update", update, 0);
      check("reset ovf", ovf, 0);
      check("reset in_ready", in_ready, 0);
    end else if (update) begin
      if (exp_q.size() == 0) begin
        check("unexpected update", update, 0);
      end else begin
        e = exp_q.pop_front();
        $display("update: num=%0d char=%h ovf=%0b", num_out, char_out, ovf);
        check("upd num_out", num_out, e.num);
        check("upd char_out", char_out, e.ch);
        check("upd ovf", ovf, e.ovf);
        last = e;
      end
    end else begin
      check("hold outputs", {num_out, char_out, ovf}, {last.num, last.ch, last.ovf});
    end
  end

  initial begin
    bit a;
    rst      = 1'b1;
    in_valid = 1'b0;
    in_data  = '0;
    label    = 7'h20;
    lab_cur  = 7'h20;
    cyc      = 0;
    reset_dut();

    // Plain average
    lab_cur = 7'h56;
    send(16'd100); send(16'd200); send(16'd300); send(16'd400);
    idle(40);
    // Negative average floors toward minus infinity
    lab_cur = 7'h41;
    send(16'hFFFF); send(16'hFFFF); send(16'hFFFF); send(16'hFFFE);
    idle(40);
    // Clamping both signs
    for (int i = 0; i < 4; i++) send(16'd20000);
    idle(40);
    for (int i = 0; i < 4; i++) send(16'h8000);
    idle(40);
    // Two windows between ticks: latest wins, then an empty tick
    while ((cyc % CLK_DIV) != 0) idle(1);
    for (int i = 0; i < 4; i++) send(16'd10);
    for (int i = 0; i < 4; i++) send(16'd30);
    idle(40);
    // IN_VALID held high across publish cycles
    for (int i = 0; i < 40; i++) cycle(1'b1, 16'($urandom_range(0, 2000)), a);
    idle(40);
    // Window completing exactly on the tick cycle
    send(16'd7); send(16'd7); send(16'd7);
    for (int i = 0; i < 40 && (cyc % CLK_DIV) != CLK_DIV - 1; i++) idle(1);
    send(16'd11);
    idle(40);
    // Reset mid-window discards partial samples
    send(16'd5000); send(16'd5000); send(16'd5000);
    reset_dut();
    send(16'd40); send(16'd44); send(16'd48); send(16'd52);
    idle(40);
    // Reset during the publish cycle: no UPDATE may appear
    for (int i = 0; i < 4; i++) send(16'd1234);
    for (int i = 0; i < 40 && !m_pub; i++) idle(1);
    check("publish reached", m_pub, 1);
    reset_dut();
    idle(40);
    // Randomized traffic
    for (int i = 0; i < 1500; i++) begin
      logic [15:0] d;
      case ($urandom_range(0, 3))
        0:       d = ($urandom_range(0, 1) == 1) ? 16'h8000 : 16'h7FFF;
        1:       d = 16'($signed($urandom_range(0, 4000)) - 2000);
        default: d = 16'($urandom);
      endcase
      if ($urandom_range(0, 15) == 0) lab_cur = 7'($urandom);
      cycle($urandom_range(0, 9) < 6, d, a);
      if ($urandom_range(0, 499) == 0) reset_dut();
    end
    idle(40);
    check("queue drained", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
